// File: rtl/sensor_status_pkg.sv
// Shared types, default timing and width helper for the sensor status conditioning stage.
package sensor_status_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // Defaults assume a 50 MHz system clock.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_STARTUP_CYCLES  = 2_500_000;
    localparam int unsigned DEF_HOLDOFF_CYCLES  = 5_000_000;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sensor_status_sync_if.sv
// Raw sensor inputs and published status outputs of sensor_status_sync.
interface sensor_status_sync_if;

    logic [3:0] water_raw;
    logic [3:0] food_raw;
    logic [3:0] water_o;
    logic [3:0] food_o;
    logic       ready_o;
    logic       change_o;

    modport master (
        output water_raw,
        output food_raw,
        input  water_o,
        input  food_o,
        input  ready_o,
        input  change_o
    );

    modport slave (
        input  water_raw,
        input  food_raw,
        output water_o,
        output food_o,
        output ready_o,
        output change_o
    );

endinterface

// File: rtl/debounce_bit.sv
// Two-flop synchronizer followed by a mismatch-run debouncer for one asynchronous bit.
module debounce_bit
    import sensor_status_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic db_o
);

    localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync0_q, sync1_q;
    logic            db_q, db_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter only runs on a continuous mismatch, so it never passes CntLast.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync1_q != db_q) begin
            if (cnt_q == CntLast) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync0_q <= raw_i;
            sync1_q <= sync0_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/sensor_status_sync.sv
// Conditions raw water/food sensor nibbles into clean, rate-limited status for the LCD controller.
module sensor_status_sync
    import sensor_status_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned STARTUP_CYCLES  = DEF_STARTUP_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input logic clk,
    input logic reset,
    sensor_status_sync_if.slave bus_io
);

    localparam int unsigned     TimerMax  = (STARTUP_CYCLES > HOLDOFF_CYCLES) ?
                                            STARTUP_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned     TmrW      = cnt_width(TimerMax);
    localparam logic [TmrW-1:0] StartLast = TmrW'(STARTUP_CYCLES - 1);
    localparam logic [TmrW-1:0] HoldLast  = TmrW'(HOLDOFF_CYCLES - 1);

    logic [3:0] db_water, db_food;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_water (
            .clk  (clk),
            .reset(reset),
            .raw_i(bus_io.water_raw[i]),
            .db_o (db_water[i])
        );

        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_food (
            .clk  (clk),
            .reset(reset),
            .raw_i(bus_io.food_raw[i]),
            .db_o (db_food[i])
        );
    end

    state_e          state_q;
    logic [TmrW-1:0] tmr_q;
    logic [3:0]      water_q, food_q;
    logic            ready_q, change_q;

    // One timer serves both the startup settle and the post-publish holdoff.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_INIT;
            tmr_q    <= '0;
            water_q  <= 4'd0;
            food_q   <= 4'd0;
            ready_q  <= 1'b0;
            change_q <= 1'b0;
        end else begin
            change_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    if (tmr_q == StartLast) begin
                        water_q <= db_water;
                        food_q  <= db_food;
                        ready_q <= 1'b1;
                        tmr_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if ({db_water, db_food} != {water_q, food_q}) begin
                        water_q  <= db_water;
                        food_q   <= db_food;
                        change_q <= 1'b1;
                        tmr_q    <= '0;
                        state_q  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (tmr_q == HoldLast) begin
                        tmr_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: begin
                    tmr_q   <= '0;
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign bus_io.water_o  = water_q;
    assign bus_io.food_o   = food_q;
    assign bus_io.ready_o  = ready_q;
    assign bus_io.change_o = change_q;

endmodule

// File: tb/tb_sensor_status_sync.sv
// Directed bench for sensor_status_sync with short debounce/startup/holdoff intervals.
module tb_sensor_status_sync;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    sensor_status_sync_if bus ();

    sensor_status_sync #(
        .DEBOUNCE_CYCLES(4),
        .STARTUP_CYCLES (10),
        .HOLDOFF_CYCLES (8)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    // change_o is read before the edge updates it, so each pulse is counted one edge late.
    always @(posedge clk) begin
        if (bus.change_o === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.water_raw = 4'b0001;
        bus.food_raw  = 4'b0000;
        #1 reset = 1'b0;

        // 1. Startup
        tick(3);
        check("rst_water", 32'(bus.water_o), 32'h0);
        check("rst_food", 32'(bus.food_o), 32'h0);
        check("rst_ready", 32'(bus.ready_o), 32'h0);
        check("rst_change", 32'(bus.change_o), 32'h0);
        reset = 1'b1;
        tick(9);
        check("start_ready_early", 32'(bus.ready_o), 32'h0);
        check("start_water_early", 32'(bus.water_o), 32'h0);
        tick(1);
        check("start_ready", 32'(bus.ready_o), 32'h1);
        check("start_water", 32'(bus.water_o), 32'h1);
        check("start_food", 32'(bus.food_o), 32'h0);
        check("start_change", 32'(bus.change_o), 32'h0);

        // 2. Glitch rejection
        tick(2);
        bus.food_raw = 4'b0001;
        tick(3);
        bus.food_raw = 4'b0000;
        tick(10);
        check("glitch_food", 32'(bus.food_o), 32'h0);
        check("glitch_pulses", 32'(pulses), 32'd0);

        // 3. Stable change
        bus.food_raw = 4'b0001;
        tick(6);
        check("stable_food_early", 32'(bus.food_o), 32'h0);
        check("stable_change_early", 32'(bus.change_o), 32'h0);
        tick(1);
        check("stable_food", 32'(bus.food_o), 32'h1);
        check("stable_change", 32'(bus.change_o), 32'h1);
        tick(1);
        check("stable_change_end", 32'(bus.change_o), 32'h0);
        check("stable_pulses", 32'(pulses), 32'd1);
        tick(10);

        // 4. Holdoff coalescing
        bus.water_raw = 4'b0011;
        tick(7);
        check("hold_pub_water", 32'(bus.water_o), 32'h3);
        check("hold_pub_change", 32'(bus.change_o), 32'h1);
        tick(2);
        bus.water_raw = 4'b0111;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("hold_frozen_water", 32'(bus.water_o), 32'h3);
        end
        check("hold_no_change", 32'(bus.change_o), 32'h0);
        tick(1);
        check("coalesce_water", 32'(bus.water_o), 32'h7);
        check("coalesce_change", 32'(bus.change_o), 32'h1);
        tick(1);
        check("coalesce_pulses", 32'(pulses), 32'd3);
        tick(12);

        // 5. Revert in holdoff: food[1] debounces up then back down inside the holdoff
        bus.water_raw = 4'b0011;
        tick(4);
        bus.food_raw = 4'b0011;
        tick(3);
        check("revert_pub_water", 32'(bus.water_o), 32'h3);
        check("revert_pub_change", 32'(bus.change_o), 32'h1);
        tick(1);
        bus.food_raw = 4'b0001;
        tick(12);
        check("revert_food", 32'(bus.food_o), 32'h1);
        check("revert_water", 32'(bus.water_o), 32'h3);
        check("revert_pulses", 32'(pulses), 32'd4);

        // 6. Reset mid-holdoff
        bus.water_raw = 4'b0111;
        tick(7);
        check("mid_pub_water", 32'(bus.water_o), 32'h7);
        tick(2);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_water", 32'(bus.water_o), 32'h0);
        check("mid_rst_food", 32'(bus.food_o), 32'h0);
        check("mid_rst_ready", 32'(bus.ready_o), 32'h0);
        check("mid_rst_change", 32'(bus.change_o), 32'h0);
        check("mid_rst_pulses", 32'(pulses), 32'd5);
        tick(3);
        reset = 1'b1;
        tick(9);
        check("restart_ready_early", 32'(bus.ready_o), 32'h0);
        tick(1);
        check("restart_ready", 32'(bus.ready_o), 32'h1);
        check("restart_water", 32'(bus.water_o), 32'h7);
        check("restart_food", 32'(bus.food_o), 32'h1);
        tick(2);
        check("restart_pulses", 32'(pulses), 32'd5);
        check("restart_ready_held", 32'(bus.ready_o), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_status_sync.md
Name: sensor_status_sync

Overview:
- Upstream stage of the LCD1602 controller. Conditions the raw water-level and food-level sensor nibbles: synchronize, debounce, hold off, publish.
- Its outputs drive the controller's in1, in2 and ready_i ports directly.
- Guarantees the display only sees clean, rate-limited status updates. ready_o asserts only after a power-on settle interval.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a synchronized bit must differ from its debounced value before it flips (20 ms @ 50 MHz); must be >= 1.
- STARTUP_CYCLES, 2_500_000, cycles after reset release before the first publish and ready_o (50 ms); must be >= 1.
- HOLDOFF_CYCLES, 5_000_000, minimum cycles between successive publishes so the LCD can redraw (100 ms); must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- water_raw  in  4  asynchronous water sensor bits.
- food_raw  in  4  asynchronous food sensor bits.
- water_o  out  4  published water status; drives controller in1.
- food_o  out  4  published food status; drives controller in2.
- ready_o  out  1  level; drives controller ready_i.
- change_o  out  1  one-cycle pulse on every publish after startup.

Behaviour:
- Reset (reset=0, async): water_o=0, food_o=0, ready_o=0, change_o=0. All sync flops, debounced values and counters clear; state=S_INIT.
- Sync: each raw bit passes through a 2-flop synchronizer (8 bits total).
- Debounce, per bit, independent: the counter increments while sync bit != debounced bit and clears to 0 when they match. When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the debounced bit flips and the counter clears.
- Latency raw->debounced: 2 + DEBOUNCE_CYCLES cycles.
- Counter widths: $clog2(param) bits, minimum 1. No wrap is possible because each counter saturates by its clear rule.
- FSM S_INIT:
  - startup counter counts from 0 after reset release.
  - At count STARTUP_CYCLES-1: load water_o/food_o from the current debounced values, ready_o<=1, go to S_IDLE.
  - No change_o pulse for this initial load.
- FSM S_IDLE:
  - If {db_water,db_food} != {water_o,food_o}: latch the debounced values into the outputs, change_o=1 for one cycle, clear the holdoff counter, go to S_HOLD.
  - Publish latency is 1 cycle after the debounced mismatch is visible.
- FSM S_HOLD:
  - Outputs frozen; debounced changes accumulate but are not published.
  - At holdoff count HOLDOFF_CYCLES-1: go to S_IDLE.
  - A pending mismatch then publishes on the next cycle as a single coalesced update holding the latest values.
  - If the debounced values reverted to the published values during S_HOLD, nothing is published.
- Simultaneous changes on several bits in the same cycle produce one publish and one change_o pulse.
- ready_o stays 1 until reset; it never deasserts during S_HOLD.
- Reset mid-operation (any state) restarts S_INIT, including the full STARTUP interval.

Decomposition:
- Shared package sensor_status_pkg holds:
  - FSM state encodings S_INIT=2'd0, S_IDLE=2'd1, S_HOLD=2'd2;
  - default timing constants;
  - a clog2-based width helper.
- One sub-module, debounce_bit (2-flop sync + counter + debounced output, DEBOUNCE_CYCLES parameter), instantiated 8 times via generate.

Test Plan:
Bench parameters DEBOUNCE_CYCLES=4, STARTUP_CYCLES=10, HOLDOFF_CYCLES=8, 100 MHz clock.
1. Startup: hold reset=0 with water_raw=4'b0001, food_raw=0 -> outputs all 0. Release reset -> ready_o=1 and water_o=4'b0001 exactly 10 cycles after release; change_o never pulses.
2. Glitch rejection: after ready, set food_raw[0]=1 for 3 cycles, then 0 -> food_o stays 0 and no change_o.
3. Stable change: set food_raw[0]=1 and hold -> food_o=4'b0001 and a single 1-cycle change_o, 7 cycles (2+4+1) after the raw edge.
4. Holdoff coalescing: publish water_o=4'b0011. 2 cycles later set water_raw=4'b0111 -> water_o unchanged for the 8-cycle holdoff. Exactly one further change_o pulse one cycle after returning to S_IDLE, with water_o=4'b0111.
5. Revert in holdoff: during S_HOLD debounce food_raw[1] to 1 and back to 0 -> no publish after holdoff; food_o unchanged.
6. Reset mid-holdoff: drive reset=0 during S_HOLD -> water_o, food_o, ready_o, change_o all 0 immediately (asynchronous). After release, ready_o returns only after the full 10 cycles.
